// File: rtl/bitsel_axil_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : bitsel_axil_slave_if
//  Brief    : AXI4-Lite bundle for the bitsel S00_AXI port, with master and
//             slave views.
//  Revision : 1.0  initial release
// ============================================================================
interface bitsel_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  // write address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  // write data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  // write response channel
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  // read address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  // read data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface
`default_nettype wire

// File: rtl/bitsel_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module   : bitsel_axil_slave
//  Brief    : AXI4-Lite register slave for the bitsel IP. Holds a small
//             control register file and drives bit_out = reg0[reg1[4:0]].
//  Revision : 1.0  initial release
// ============================================================================
module bitsel_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_REG_COUNT        = 4
) (
  input  logic               ACLK,
  input  logic               ARESET,
  bitsel_axil_slave_if.slave S_AXI,
  output logic               bit_out
);

  localparam int         c_IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
  localparam int         c_SEL_W       = (C_REG_COUNT > 1) ? $clog2(C_REG_COUNT) : 1;
  localparam int         c_STRB_W      = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [C_REG_COUNT];

  // write-side holds: each channel parks its beat until the other arrives
  logic                          r_aw_full;
  logic [c_IDX_W-1:0]            r_aw_idx;
  logic                          r_w_full;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
  logic [c_STRB_W-1:0]           r_w_strb;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;

  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                    r_rresp;
  logic                          r_bit_out;

  logic                          w_awready;
  logic                          w_wready;
  logic                          w_arready;
  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_ar_hs;
  logic                          w_commit;
  logic                          w_aw_ok;
  logic                          w_ar_ok;
  logic [c_IDX_W-1:0]            w_ar_idx;
  logic                          w_unused_ok;

  // Readies are gated by reset so they read 0 while reset is held.
  assign w_awready = ~ARESET & ~r_aw_full & ~r_bvalid;
  assign w_wready  = ~ARESET & ~r_w_full  & ~r_bvalid;
  assign w_arready = ~ARESET & ~r_rvalid;

  assign w_aw_hs  = S_AXI.S_AXI_AWVALID & w_awready;
  assign w_w_hs   = S_AXI.S_AXI_WVALID  & w_wready;
  assign w_ar_hs  = S_AXI.S_AXI_ARVALID & w_arready;
  assign w_commit = r_aw_full & r_w_full;

  assign w_ar_idx = S_AXI.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_aw_ok  = (int'(r_aw_idx) < C_REG_COUNT);
  assign w_ar_ok  = (int'(w_ar_idx) < C_REG_COUNT);

  // Protection bits and byte-offset address bits carry no meaning here.
  assign w_unused_ok = &{1'b0, S_AXI.S_AXI_AWPROT, S_AXI.S_AXI_ARPROT,
                         S_AXI.S_AXI_AWADDR[1:0], S_AXI.S_AXI_ARADDR[1:0]};

  assign S_AXI.S_AXI_AWREADY = w_awready;
  assign S_AXI.S_AXI_WREADY  = w_wready;
  assign S_AXI.S_AXI_ARREADY = w_arready;
  assign S_AXI.S_AXI_BVALID  = r_bvalid;
  assign S_AXI.S_AXI_BRESP   = r_bresp;
  assign S_AXI.S_AXI_RVALID  = r_rvalid;
  assign S_AXI.S_AXI_RDATA   = r_rdata;
  assign S_AXI.S_AXI_RRESP   = r_rresp;
  assign bit_out             = r_bit_out;

  // Capture AW/W beats into their holds, commit once both are full, retire B.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= S_AXI.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= S_AXI.S_AXI_WDATA;
        r_w_strb <= S_AXI.S_AXI_WSTRB;
      end
      // Readies are low while holds are full, so commit never collides with a capture.
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_ok ? c_RESP_OKAY : c_RESP_SLVERR;
      end else if (r_bvalid && S_AXI.S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register file: byte-masked update on commit of an in-range write.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < C_REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && w_aw_ok) begin
      for (int b = 0; b < c_STRB_W; b++) begin
        if (r_w_strb[b]) begin
          r_regs[r_aw_idx[c_SEL_W-1:0]][8*b +: 8] <= r_w_data[8*b +: 8];
        end
      end
    end
  end

  // Read channel: data registered at the AR handshake, held until accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= c_RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_ok ? r_regs[w_ar_idx[c_SEL_W-1:0]] : '0;
      r_rresp  <= w_ar_ok ? c_RESP_OKAY : c_RESP_SLVERR;
    end else if (r_rvalid && S_AXI.S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // Bit select follows reg0/reg1 with one cycle of latency.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_bit_out <= 1'b0;
    end else begin
      r_bit_out <= r_regs[0][r_regs[1][4:0]];
    end
  end

endmodule
`default_nettype wire
